// File: rtl/multi_debouncer.sv
// N-channel button/switch debouncer: per-channel synchroniser feeding a
// LISTEN/HOLD FSM that emits one-cycle rise/fall pulses and then ignores its input.

module mdb_lane #(
  parameter int HOLD_CYCLES = 256,
  parameter int SYNC_STAGES = 2,
  parameter bit INIT_LEVEL  = 1'b0,
  parameter int CNT_W       = $clog2(HOLD_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  typedef enum logic {LISTEN = 1'b0, HOLD = 1'b1} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{INIT_LEVEL}};
      state_q <= LISTEN;
      cnt_q   <= '0;
      level_q <= INIT_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      LISTEN: begin
        if (s != level_q) begin
          level_d = s;
          rise_d  = s;
          fall_d  = ~s;
          cnt_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Terminal compare exits before the counter could wrap.
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = LISTEN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = LISTEN;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign busy_o  = (state_q == HOLD);

endmodule

module multi_debouncer #(
  parameter int N_CH        = 4,
  parameter int HOLD_CYCLES = 256,
  parameter int SYNC_STAGES = 2,
  parameter bit INIT_LEVEL  = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] bouncy_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] busy
);

  localparam int CNT_W = $clog2(HOLD_CYCLES);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    mdb_lane #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .SYNC_STAGES (SYNC_STAGES),
      .INIT_LEVEL  (INIT_LEVEL),
      .CNT_W       (CNT_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .din_i   (bouncy_in[c]),
      .level_o (level_out[c]),
      .rise_o  (rise_pulse[c]),
      .fall_o  (fall_pulse[c]),
      .busy_o  (busy[c])
    );
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: directed scenarios plus random stimulus, each
// cycle compared against a queue/countdown model of the debouncer rules.

module tb_multi_debouncer;

  localparam int N_CH        = 2;
  localparam int HOLD_CYCLES = 8;
  localparam int SYNC_STAGES = 2;
  localparam bit INIT_LEVEL  = 1'b0;

  logic            clk;
  logic            rst;
  logic [N_CH-1:0] bouncy_in;
  logic [N_CH-1:0] level_out, rise_pulse, fall_pulse, busy;

  int ntot  = 0;
  int npass = 0;
  int nrise0, nfall0;

  // Model: per-channel delay queue of samples, level, and remaining hold cycles.
  bit              dq[N_CH][$];
  logic [N_CH-1:0] m_level, m_rise, m_fall, m_busy;
  int              hold_left[N_CH];

  multi_debouncer #(
    .N_CH        (N_CH),
    .HOLD_CYCLES (HOLD_CYCLES),
    .SYNC_STAGES (SYNC_STAGES),
    .INIT_LEVEL  (INIT_LEVEL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bouncy_in  (bouncy_in),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Checks the DUT and the model against one hand-derived value.
  task automatic lit(input string nm, input logic [N_CH-1:0] d, input logic [N_CH-1:0] m,
                     input logic [N_CH-1:0] e);
    chk({nm, "_dut"}, 32'(d), 32'(e));
    chk({nm, "_model"}, 32'(m), 32'(e));
  endtask

  task automatic model_step(input bit r, input logic [N_CH-1:0] x);
    bit s;
    for (int c = 0; c < N_CH; c++) begin
      m_rise[c] = 1'b0;
      m_fall[c] = 1'b0;
      if (r) begin
        dq[c].delete();
        repeat (SYNC_STAGES) dq[c].push_back(INIT_LEVEL);
        m_level[c]   = INIT_LEVEL;
        hold_left[c] = 0;
      end else begin
        s = dq[c].pop_front();
        dq[c].push_back(x[c]);
        if (hold_left[c] > 0) hold_left[c]--;
        else if (s != m_level[c]) begin
          m_level[c]   = s;
          m_rise[c]    = s;
          m_fall[c]    = !s;
          hold_left[c] = HOLD_CYCLES;
        end
      end
      m_busy[c] = (hold_left[c] > 0);
    end
  endtask

  // One clock: drive, let the edge happen, advance model, compare on negedge.
  task automatic step(input bit r, input logic [N_CH-1:0] x);
    rst       = r;
    bouncy_in = x;
    @(posedge clk);
    model_step(r, x);
    @(negedge clk);
    chk("outs", {level_out, rise_pulse, fall_pulse, busy}, {m_level, m_rise, m_fall, m_busy});
    chk("excl", 32'(|(rise_pulse & fall_pulse)), 32'd0);
    nrise0 += int'(rise_pulse[0]);
    nfall0 += int'(fall_pulse[0]);
  endtask

  initial begin
    logic [N_CH-1:0] x;
    bit              r;
    nrise0 = 0;
    nfall0 = 0;

    // 1: reset and quiet
    repeat (3) step(1'b1, '0);
    lit("t1_level", level_out, m_level, 2'b00);
    lit("t1_busy", busy, m_busy, 2'b00);
    nrise0 = 0; nfall0 = 0;
    repeat (20) step(1'b0, '0);
    chk("t1_nopulse", 32'(nrise0 + nfall0), 32'd0);

    // 2+3: ch0 rises, then bounces during HOLD
    repeat (2) step(1'b1, '0);
    nrise0 = 0; nfall0 = 0;
    step(1'b0, 2'b01);                    // E1
    step(1'b0, 2'b01);                    // E2
    lit("t2_e2_rise", rise_pulse, m_rise, 2'b00);
    step(1'b0, 2'b01);                    // E3
    lit("t2_e3_rise", rise_pulse, m_rise, 2'b01);
    lit("t2_e3_level", level_out, m_level, 2'b01);
    lit("t2_e3_busy", busy, m_busy, 2'b01);
    step(1'b0, 2'b01);                    // E4..E8 bounce 1,0,1,0,1
    step(1'b0, 2'b00);
    step(1'b0, 2'b01);
    step(1'b0, 2'b00);
    step(1'b0, 2'b01);
    step(1'b0, 2'b01);                    // E9
    step(1'b0, 2'b01);                    // E10
    lit("t2_e10_busy", busy, m_busy, 2'b01);
    step(1'b0, 2'b01);                    // E11
    lit("t2_e11_busy", busy, m_busy, 2'b00);
    repeat (9) step(1'b0, 2'b01);
    chk("t3_one_rise", 32'(nrise0), 32'd1);
    chk("t3_no_fall", 32'(nfall0), 32'd0);
    lit("t3_level", level_out, m_level, 2'b01);

    // 4: ch0 drops at E5, fall only on the first LISTEN cycle
    repeat (2) step(1'b1, '0);
    for (int e = 1; e <= 4; e++) step(1'b0, 2'b01);
    for (int e = 5; e <= 11; e++) step(1'b0, 2'b00);
    lit("t4_e11_fall", fall_pulse, m_fall, 2'b00);
    step(1'b0, 2'b00);                    // E12
    lit("t4_e12_fall", fall_pulse, m_fall, 2'b01);
    lit("t4_e12_rise", rise_pulse, m_rise, 2'b00);
    lit("t4_e12_level", level_out, m_level, 2'b00);

    // 5: both channels rise together
    repeat (2) step(1'b1, '0);
    for (int e = 1; e <= 3; e++) step(1'b0, 2'b11);
    lit("t5_e3_rise", rise_pulse, m_rise, 2'b11);
    lit("t5_e3_busy", busy, m_busy, 2'b11);
    for (int e = 4; e <= 10; e++) step(1'b0, 2'b11);
    lit("t5_e10_busy", busy, m_busy, 2'b11);
    step(1'b0, 2'b11);
    lit("t5_e11_busy", busy, m_busy, 2'b00);

    // 6: reset mid-HOLD aborts, then re-accepts after the synchroniser fills
    repeat (2) step(1'b1, '0);
    for (int e = 1; e <= 5; e++) step(1'b0, 2'b01);
    step(1'b1, 2'b01);                    // E6
    lit("t6_rst_level", level_out, m_level, 2'b00);
    lit("t6_rst_busy", busy, m_busy, 2'b00);
    lit("t6_rst_rise", rise_pulse, m_rise, 2'b00);
    step(1'b0, 2'b01);                    // E7
    step(1'b0, 2'b01);                    // E8
    lit("t6_e8_rise", rise_pulse, m_rise, 2'b00);
    step(1'b0, 2'b01);                    // E9
    lit("t6_e9_rise", rise_pulse, m_rise, 2'b01);

    // Random: slow-ish toggling with occasional bounce bursts and resets
    x = '0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 249) == 0);
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, 5) == 0) x[c] = ~x[c];
      step(r, x);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
